// File: rtl/agc_multistep.sv
// agc_multistep -- multi-step automatic gain control for an ADC front end.
//
// Collects WIN_LEN valid samples into a peak/trough window, evaluates a
// metric (peak, or peak-to-peak when mode=1) against per-step limits, and
// steps the relay gain index after HYST_WIN consecutive out-of-range windows.
// An instantaneous sample at or above OV_THR forces an immediate step down.
// After every gain change SETTLE_SAMPLES valid samples are discarded.
//
// Build option: define AGC_WATCHDOG_EN to add a watchdog that returns the
// block to its reset state after WDOG_CYCLES clk cycles without adc_valid.
// Without it, wdog_trip is tied low and the FSM waits indefinitely.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   adc_valid, adc_data        sample strobe and sample
//   mode                       0 = peak metric, 1 = peak-to-peak metric
//   lim_lo_flat, lim_hi_flat   per-step limits, step i at [i*ADC_W +: ADC_W]
//   force_en, force_idx        manual gain override
//   relay_ctrl                 current gain index
//   stable, at_limit           in-range flag, end-stop saturation flag
//   metric_out, metric_valid   last evaluated metric and its one-cycle strobe
//   wdog_trip                  one-cycle watchdog pulse
module agc_multistep #(
  parameter int ADC_W          = 12,
  parameter int GAIN_STEPS     = 4,
  parameter int WIN_LEN        = 512,
  parameter int OV_THR         = 3941,
  parameter int HYST_WIN       = 2,
  parameter int SETTLE_SAMPLES = 6,
  parameter int WDOG_CYCLES    = 20'hFFFFF,
  localparam int GAIN_W        = $clog2(GAIN_STEPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adc_valid,
  input  logic [ADC_W-1:0]           adc_data,
  input  logic                       mode,
  input  logic [GAIN_STEPS*ADC_W-1:0] lim_lo_flat,
  input  logic [GAIN_STEPS*ADC_W-1:0] lim_hi_flat,
  input  logic                       force_en,
  input  logic [GAIN_W-1:0]          force_idx,
  output logic [GAIN_W-1:0]          relay_ctrl,
  output logic                       stable,
  output logic                       at_limit,
  output logic [ADC_W-1:0]           metric_out,
  output logic                       metric_valid,
  output logic                       wdog_trip
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int HC_W  = $clog2(HYST_WIN + 1);
  localparam int ST_W  = $clog2(SETTLE_SAMPLES + 2);
  localparam logic [GAIN_W-1:0] IDX_MAX = GAIN_W'(GAIN_STEPS - 1);

  typedef enum logic [2:0] {INIT, SAMPLE, EVAL, ADJUST, SETTLE} state_t;

  state_t             state_reg, state_next;
  logic [GAIN_W-1:0]  idx_reg, idx_next;
  logic [GAIN_W-1:0]  tgt_reg, tgt_next;        // index applied by ADJUST
  logic               stable_reg, stable_next;
  logic               at_limit_reg, at_limit_next;
  logic [ADC_W-1:0]   metric_out_reg, metric_out_next;
  logic               metric_valid_reg, metric_valid_next;
  logic [ADC_W-1:0]   peak_reg, peak_next;
  logic [ADC_W-1:0]   trough_reg, trough_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [HC_W-1:0]    hi_cnt_reg, hi_cnt_next;
  logic [HC_W-1:0]    lo_cnt_reg, lo_cnt_next;
  logic [ST_W-1:0]    settle_reg, settle_next;

  logic [ADC_W-1:0]   lo_cur, hi_cur, metric;
  logic [HC_W-1:0]    hi_inc, lo_inc;
  logic [GAIN_W-1:0]  force_clamped;

  assign lo_cur = lim_lo_flat[idx_reg*ADC_W +: ADC_W];
  assign hi_cur = lim_hi_flat[idx_reg*ADC_W +: ADC_W];
  // trough never exceeds peak once a window holds a sample, so no underflow
  assign metric = mode ? (peak_reg - trough_reg) : peak_reg;
  assign hi_inc = hi_cnt_reg + 1'b1;
  assign lo_inc = lo_cnt_reg + 1'b1;
  assign force_clamped = (force_idx > IDX_MAX) ? IDX_MAX : force_idx;

`ifdef AGC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_hit;
  logic            wdog_trip_reg;

  // Counter saturates after a trip and only restarts on the next sample.
  assign wd_hit = !adc_valid && (wd_cnt_reg == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg    <= '0;
      wdog_trip_reg <= 1'b0;
    end else begin
      wdog_trip_reg <= wd_hit;
      if (adc_valid)
        wd_cnt_reg <= '0;
      else if (wd_cnt_reg != WD_W'(WDOG_CYCLES))
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign wdog_trip = wdog_trip_reg;
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    tgt_next          = tgt_reg;
    stable_next       = stable_reg;
    at_limit_next     = at_limit_reg;
    metric_out_next   = metric_out_reg;
    metric_valid_next = 1'b0;
    peak_next         = peak_reg;
    trough_next       = trough_reg;
    cnt_next          = cnt_reg;
    hi_cnt_next       = hi_cnt_reg;
    lo_cnt_next       = lo_cnt_reg;
    settle_next       = settle_reg;

    case (state_reg)
      INIT: begin
        peak_next   = '0;
        trough_next = '1;
        cnt_next    = '0;
        state_next  = SAMPLE;
      end
      SAMPLE: begin
        if (adc_valid) begin
          if (adc_data >= ADC_W'(OV_THR)) begin
            // over-voltage abandons the window and steps down at once
            tgt_next    = (idx_reg == '0) ? '0 : idx_reg - 1'b1;
            hi_cnt_next = '0;
            lo_cnt_next = '0;
            stable_next = 1'b0;
            state_next  = ADJUST;
          end else begin
            if (adc_data > peak_reg)   peak_next   = adc_data;
            if (adc_data < trough_reg) trough_next = adc_data;
            if (cnt_reg == CNT_W'(WIN_LEN - 1))
              state_next = EVAL;
            else
              cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      EVAL: begin
        metric_out_next   = metric;
        metric_valid_next = 1'b1;
        state_next        = INIT;
        if (metric > hi_cur) begin
          lo_cnt_next = '0;
          if (hi_inc >= HC_W'(HYST_WIN)) begin
            hi_cnt_next = '0;
            if (idx_reg != '0) begin
              tgt_next   = idx_reg - 1'b1;
              state_next = ADJUST;
            end else begin
              at_limit_next = 1'b1;
              stable_next   = 1'b0;
            end
          end else begin
            hi_cnt_next = hi_inc;
          end
        end else if (metric < lo_cur) begin
          hi_cnt_next = '0;
          if (lo_inc >= HC_W'(HYST_WIN)) begin
            lo_cnt_next = '0;
            if (idx_reg != IDX_MAX) begin
              tgt_next   = idx_reg + 1'b1;
              state_next = ADJUST;
            end else begin
              at_limit_next = 1'b1;
              stable_next   = 1'b0;
            end
          end else begin
            lo_cnt_next = lo_inc;
          end
        end else begin
          stable_next   = 1'b1;
          at_limit_next = 1'b0;
          hi_cnt_next   = '0;
          lo_cnt_next   = '0;
        end
      end
      ADJUST: begin
        idx_next      = tgt_reg;
        stable_next   = 1'b0;
        at_limit_next = 1'b0;
        settle_next   = '0;
        state_next    = SETTLE;
      end
      SETTLE: begin
        if (settle_reg >= ST_W'(SETTLE_SAMPLES))
          state_next = INIT;
        else if (adc_valid)
          settle_next = settle_reg + 1'b1;
      end
      default: state_next = INIT;
    endcase

    // manual override wins over whatever the FSM decided this cycle
    if (force_en) begin
      idx_next    = force_clamped;
      state_next  = INIT;
      stable_next = 1'b0;
      hi_cnt_next = '0;
      lo_cnt_next = '0;
    end

`ifdef AGC_WATCHDOG_EN
    if (wd_hit) begin
      state_next        = INIT;
      idx_next          = '0;
      tgt_next          = '0;
      stable_next       = 1'b0;
      at_limit_next     = 1'b0;
      metric_out_next   = '0;
      metric_valid_next = 1'b0;
      peak_next         = '0;
      trough_next       = '1;
      cnt_next          = '0;
      hi_cnt_next       = '0;
      lo_cnt_next       = '0;
      settle_next       = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= INIT;
      idx_reg          <= '0;
      tgt_reg          <= '0;
      stable_reg       <= 1'b0;
      at_limit_reg     <= 1'b0;
      metric_out_reg   <= '0;
      metric_valid_reg <= 1'b0;
      peak_reg         <= '0;
      trough_reg       <= '1;
      cnt_reg          <= '0;
      hi_cnt_reg       <= '0;
      lo_cnt_reg       <= '0;
      settle_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      tgt_reg          <= tgt_next;
      stable_reg       <= stable_next;
      at_limit_reg     <= at_limit_next;
      metric_out_reg   <= metric_out_next;
      metric_valid_reg <= metric_valid_next;
      peak_reg         <= peak_next;
      trough_reg       <= trough_next;
      cnt_reg          <= cnt_next;
      hi_cnt_reg       <= hi_cnt_next;
      lo_cnt_reg       <= lo_cnt_next;
      settle_reg       <= settle_next;
    end
  end

  assign relay_ctrl   = idx_reg;
  assign stable       = stable_reg;
  assign at_limit     = at_limit_reg;
  assign metric_out   = metric_out_reg;
  assign metric_valid = metric_valid_reg;

endmodule
